ahb_master_arbiter: RTL and testbench

//  Two-master AHB-Lite arbiter in front of the ahb_multiplexor. Replaces the static override_ctrl mux.

---
 rtl/ahb_master_arbiter.sv | 148 ++++++++++++++
 tb/tb_ahb_master_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter: grant moves only on transfer/burst boundaries, slave responses
// follow the data-phase owner, and a hold counter bounds tenure while the other master waits.
module ahb_master_arbiter #(
  parameter int   ADDR_W      = 32,
  parameter int   DATA_W      = 32,
  parameter int   MAX_HOLD    = 16,
  parameter logic PARK_MASTER = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dbg_override,
  input  logic [ADDR_W-1:0] m0_haddr,
  input  logic [2:0]        m0_hburst,
  input  logic [2:0]        m0_hsize,
  input  logic [1:0]        m0_htrans,
  input  logic              m0_hwrite,
  input  logic [DATA_W-1:0] m0_hwdata,
  output logic              m0_hready,
  output logic [DATA_W-1:0] m0_hrdata,
  output logic              m0_hresp,
  input  logic [ADDR_W-1:0] m1_haddr,
  input  logic [2:0]        m1_hburst,
  input  logic [2:0]        m1_hsize,
  input  logic [1:0]        m1_htrans,
  input  logic              m1_hwrite,
  input  logic [DATA_W-1:0] m1_hwdata,
  output logic              m1_hready,
  output logic [DATA_W-1:0] m1_hrdata,
  output logic              m1_hresp,
  output logic [ADDR_W-1:0] s_haddr,
  output logic [2:0]        s_hburst,
  output logic [2:0]        s_hsize,
  output logic [1:0]        s_htrans,
  output logic              s_hwrite,
  output logic [DATA_W-1:0] s_hwdata,
  input  logic [DATA_W-1:0] s_hrdata,
  input  logic              s_hready,
  input  logic              s_hresp,
  output logic              grant
);

  localparam int         HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  typedef enum logic { OWN0 = 1'b0, OWN1 = 1'b1 } state_t;

  state_t            state, state_nxt;
  logic              downer, dvalid;
  logic [HOLD_W-1:0] hold_cnt, hold_inc;
  logic [3:0]        beat_cnt, beat_nxt;
  logic [1:0]        own_trans, oth_trans;
  logic [2:0]        own_burst;
  logic              own_active, own_last, boundary, req_own, req_oth;

  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
    if (v >= HOLD_W'(MAX_HOLD)) return HOLD_W'(MAX_HOLD);
    return v + HOLD_W'(1);
  endfunction

  function automatic logic [3:0] burst_len_m1(input logic [2:0] b);
    case (b)
      3'b010, 3'b011: return 4'd3;
      3'b100, 3'b101: return 4'd7;
      3'b110, 3'b111: return 4'd15;
      default:        return 4'd0;
    endcase
  endfunction

  always_comb begin
    own_trans = (state == OWN1) ? m1_htrans : m0_htrans;
    oth_trans = (state == OWN1) ? m0_htrans : m1_htrans;
    own_burst = (state == OWN1) ? m1_hburst : m0_hburst;
  end

  // htrans[1] set means NONSEQ or SEQ, i.e. a real beat
  assign own_active = own_trans[1];
  assign own_last   = (own_trans == NONSEQ && own_burst == 3'b000) ||
                      (own_trans == SEQ && beat_cnt == 4'd1);
  assign boundary   = s_hready && (own_last || (!own_active && beat_cnt == 4'd0));
  assign req_own    = (own_trans == NONSEQ);
  assign req_oth    = (oth_trans == NONSEQ);
  assign hold_inc   = own_active ? sat_inc(hold_cnt) : hold_cnt;

  always_comb begin
    state_nxt = state;
    if (boundary) begin
      if (dbg_override)
        state_nxt = OWN1;
      else if (req_own && (!req_oth || hold_inc < HOLD_W'(MAX_HOLD)))
        state_nxt = state;
      else if (req_oth)
        state_nxt = (state == OWN1) ? OWN0 : OWN1;
      else
        state_nxt = state_t'(PARK_MASTER);
    end
  end

  always_comb begin
    beat_nxt = beat_cnt;
    case (own_trans)
      NONSEQ:  beat_nxt = burst_len_m1(own_burst);
      SEQ:     if (beat_cnt != 4'd0) beat_nxt = beat_cnt - 4'd1;
      IDLE:    beat_nxt = 4'd0;
      default: beat_nxt = beat_cnt;
    endcase
    if (state_nxt != state) beat_nxt = 4'd0;
  end

  // Stage boundary: address phase -> data phase, advancing only when the slave accepts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= state_t'(PARK_MASTER);
      downer   <= PARK_MASTER;
      dvalid   <= 1'b0;
      hold_cnt <= '0;
      beat_cnt <= '0;
    end else if (s_hready) begin
      state    <= state_nxt;
      downer   <= (state == OWN1);
      dvalid   <= own_active;
      beat_cnt <= beat_nxt;
      hold_cnt <= (state_nxt != state) ? '0 : hold_inc;
    end
  end

  assign grant = (state == OWN1);

  always_comb begin
    s_haddr  = grant ? m1_haddr  : m0_haddr;
    s_hburst = grant ? m1_hburst : m0_hburst;
    s_hsize  = grant ? m1_hsize  : m0_hsize;
    s_hwrite = grant ? m1_hwrite : m0_hwrite;
    s_htrans = rst ? IDLE : (grant ? m1_htrans : m0_htrans);
    s_hwdata = downer ? m1_hwdata : m0_hwdata;
  end

  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;
  assign m0_hresp  = !rst && dvalid && !downer && s_hresp;
  assign m1_hresp  = !rst && dvalid &&  downer && s_hresp;

  // A waiting master with a pending NONSEQ is stalled; an idle one sees ready
  assign m0_hready = rst || ((!grant || (dvalid && !downer)) ? s_hready : (m0_htrans == IDLE));
  assign m1_hready = rst || (( grant || (dvalid &&  downer)) ? s_hready : (m1_htrans == IDLE));

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: two queue-driven masters, a reference arbitration
// model checked every cycle, and hand-computed grant/ready/data points per scenario.
`timescale 1ns/1ps
module tb_ahb_master_arbiter;
  localparam int   AW   = 32;
  localparam int   DW   = 32;
  localparam int   MH   = 16;
  localparam logic PARK = 1'b0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dbg_override;
  logic [AW-1:0] m0_haddr, m1_haddr, s_haddr;
  logic [2:0]    m0_hburst, m1_hburst, s_hburst, m0_hsize, m1_hsize, s_hsize;
  logic [1:0]    m0_htrans, m1_htrans, s_htrans;
  logic          m0_hwrite, m1_hwrite, s_hwrite;
  logic [DW-1:0] m0_hwdata, m1_hwdata, s_hwdata, m0_hrdata, m1_hrdata, s_hrdata;
  logic          m0_hready, m1_hready, s_hready, m0_hresp, m1_hresp, s_hresp, grant;

  always #5 clk = ~clk;

  ahb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH), .PARK_MASTER(PARK)) dut (
    .clk(clk), .rst(rst), .dbg_override(dbg_override),
    .m0_haddr(m0_haddr), .m0_hburst(m0_hburst), .m0_hsize(m0_hsize), .m0_htrans(m0_htrans),
    .m0_hwrite(m0_hwrite), .m0_hwdata(m0_hwdata), .m0_hready(m0_hready), .m0_hrdata(m0_hrdata),
    .m0_hresp(m0_hresp),
    .m1_haddr(m1_haddr), .m1_hburst(m1_hburst), .m1_hsize(m1_hsize), .m1_htrans(m1_htrans),
    .m1_hwrite(m1_hwrite), .m1_hwdata(m1_hwdata), .m1_hready(m1_hready), .m1_hrdata(m1_hrdata),
    .m1_hresp(m1_hresp),
    .s_haddr(s_haddr), .s_hburst(s_hburst), .s_hsize(s_hsize), .s_htrans(s_htrans),
    .s_hwrite(s_hwrite), .s_hwdata(s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready),
    .s_hresp(s_hresp), .grant(grant)
  );

  typedef struct {
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } beat_t;

  beat_t q0[$], q1[$];
  bit    sq[$];
  bit    pres0, pres1, rdy0, rdy1, ovr_req;
  int    n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner, data-phase owner, burst progress, beats held
  logic [1:0]  tr[2];
  logic [2:0]  bu[2], sz[2];
  logic [31:0] ad[2], wd[2];
  logic        wr[2];
  int          mg, mdo, blen, bdone, held;
  bit          mdv;

  function automatic int blen_of(input logic [2:0] b);
    case (b)
      3'b000:         return 1;
      3'b001:         return 0;
      3'b010, 3'b011: return 4;
      3'b100, 3'b101: return 8;
      default:        return 16;
    endcase
  endfunction

  always @(negedge clk) begin : model
    int  ha, nw;
    bit  act, last, between;
    logic er, eh;
    tr[0] = m0_htrans; bu[0] = m0_hburst; sz[0] = m0_hsize; ad[0] = m0_haddr; wr[0] = m0_hwrite; wd[0] = m0_hwdata;
    tr[1] = m1_htrans; bu[1] = m1_hburst; sz[1] = m1_hsize; ad[1] = m1_haddr; wr[1] = m1_hwrite; wd[1] = m1_hwdata;
    if (rst) begin
      mg = int'(PARK); mdo = int'(PARK); mdv = 0; blen = 0; bdone = 0; held = 0;
    end
    chk("grant", grant, 32'(mg));
    chk("s_htrans", s_htrans, rst ? 32'd0 : 32'(tr[mg]));
    chk("s_haddr", s_haddr, ad[mg]);
    chk("s_hburst", s_hburst, 32'(bu[mg]));
    chk("s_hsize", s_hsize, 32'(sz[mg]));
    chk("s_hwrite", s_hwrite, 32'(wr[mg]));
    chk("s_hwdata", s_hwdata, wd[mdo]);
    for (int n = 0; n < 2; n++) begin
      if (rst) er = 1'b1;
      else if (n == mg || (mdv && mdo == n)) er = s_hready;
      else er = (tr[n] == 2'b00);
      eh = (!rst && mdv && mdo == n) ? s_hresp : 1'b0;
      chk(n == 0 ? "m0_hready" : "m1_hready", n == 0 ? m0_hready : m1_hready, 32'(er));
      chk(n == 0 ? "m0_hresp" : "m1_hresp", n == 0 ? m0_hresp : m1_hresp, 32'(eh));
      chk(n == 0 ? "m0_hrdata" : "m1_hrdata", n == 0 ? m0_hrdata : m1_hrdata, s_hrdata);
    end
    rdy0 = m0_hready;
    rdy1 = m1_hready;
    if (!rst && s_hready) begin
      act     = tr[mg][1];
      last    = (tr[mg] == 2'b10 && blen_of(bu[mg]) == 1) ||
                (tr[mg] == 2'b11 && blen != 0 && bdone + 1 == blen);
      between = !act && (blen == 0 || bdone >= blen);
      ha      = act ? ((held + 1 > MH) ? MH : held + 1) : held;
      nw      = mg;
      if (last || between) begin
        if (dbg_override) nw = 1;
        else if (tr[mg] == 2'b10 && (tr[1-mg] != 2'b10 || ha < MH)) nw = mg;
        else if (tr[1-mg] == 2'b10) nw = 1 - mg;
        else nw = int'(PARK);
      end
      mdo = mg;
      mdv = act;
      if (tr[mg] == 2'b10) begin blen = blen_of(bu[mg]); bdone = 1; end
      else if (tr[mg] == 2'b11) bdone++;
      else if (tr[mg] == 2'b00) begin blen = 0; bdone = 0; end
      held = ha;
      if (nw != mg) begin held = 0; blen = 0; bdone = 0; end
      mg = nw;
    end
  end

  task automatic push(input int n, input logic [1:0] t, input logic [2:0] b,
                      input logic [31:0] a, input logic w, input logic [31:0] d);
    beat_t x;
    x.trans = t; x.burst = b; x.addr = a; x.write = w; x.wdata = d;
    if (n == 0) q0.push_back(x); else q1.push_back(x);
  endtask

  task automatic step();
    beat_t b;
    @(posedge clk); #1;
    if (pres0 && rdy0) begin b = q0.pop_front(); m0_hwdata = b.wdata; end
    if (pres1 && rdy1) begin b = q1.pop_front(); m1_hwdata = b.wdata; end
    pres0 = (q0.size() > 0);
    pres1 = (q1.size() > 0);
    if (pres0) begin
      m0_htrans = q0[0].trans; m0_hburst = q0[0].burst; m0_haddr = q0[0].addr; m0_hwrite = q0[0].write;
    end else m0_htrans = 2'b00;
    if (pres1) begin
      m1_htrans = q1[0].trans; m1_hburst = q1[0].burst; m1_haddr = q1[0].addr; m1_hwrite = q1[0].write;
    end else m1_htrans = 2'b00;
    dbg_override = ovr_req;
    s_hready = (sq.size() > 0) ? sq.pop_front() : 1'b1;
    s_hrdata = $urandom;
    s_hresp  = 1'($urandom_range(0, 1));
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; ovr_req = 0; dbg_override = 1'b0;
    q0.delete(); q1.delete(); sq.delete(); pres0 = 0; pres1 = 0;
    m0_htrans = 2'b00; m1_htrans = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dw[4];
    dw[0] = 32'hD0000000; dw[1] = 32'hD0000001; dw[2] = 32'hD0000002; dw[3] = 32'hD0000003;
    dbg_override = 1'b0; ovr_req = 0;
    m0_haddr = '0; m0_hburst = '0; m0_hsize = 3'b010; m0_htrans = '0; m0_hwrite = 1'b0; m0_hwdata = '0;
    m1_haddr = '0; m1_hburst = '0; m1_hsize = 3'b010; m1_htrans = '0; m1_hwrite = 1'b0; m1_hwdata = '0;
    s_hrdata = '0; s_hready = 1'b1; s_hresp = 1'b0;

    // CPU single reads back-to-back, debug idle
    do_reset();
    chk("rst_grant", grant, 32'd0);
    chk("rst_m1_hready", m1_hready, 32'd1);
    for (int i = 0; i < 4; i++) push(0, 2'b10, 3'b000, 32'h1000 + 32'(4*i), 1'b0, 32'd0);
    step();
    chk("t1_zero_lat_addr", s_haddr, 32'h1000);
    chk("t1_grant", grant, 32'd0);
    step();
    chk("t1_addr2", s_haddr, 32'h1004);
    repeat (3) step();
    chk("t1_grant_end", grant, 32'd0);

    // Hold limit: CPU keeps requesting while debug waits
    do_reset();
    for (int i = 0; i < 20; i++) push(0, 2'b10, 3'b000, 32'h3000 + 32'(4*i), 1'b0, 32'd0);
    push(1, 2'b10, 3'b000, 32'h4000, 1'b1, 32'hD0D00001);
    for (int c = 1; c <= 16; c++) begin
      step();
      chk("t2_grant_hold", grant, 32'd0);
      chk("t2_m1_stall", m1_hready, 32'd0);
    end
    step();
    chk("t2_grant_sw", grant, 32'd1);
    chk("t2_addr_dbg", s_haddr, 32'h4000);
    chk("t2_m0_dphase_rdy", m0_hready, 32'd1);
    repeat (6) step();

    // Debug INCR4 write while the CPU requests
    do_reset();
    push(1, 2'b10, 3'b011, 32'h2000, 1'b1, dw[0]);
    for (int i = 1; i < 4; i++) push(1, 2'b11, 3'b011, 32'h2000 + 32'(4*i), 1'b1, dw[i]);
    step();
    chk("t3_grant_c1", grant, 32'd0);
    push(0, 2'b10, 3'b000, 32'h5000, 1'b0, 32'd0);
    for (int c = 2; c <= 5; c++) begin
      step();
      chk("t3_grant_burst", grant, 32'd1);
      chk("t3_m0_stall", m0_hready, 32'd0);
      if (c >= 3) chk("t3_wdata", s_hwdata, dw[c-3]);
    end
    step();
    chk("t3_grant_back", grant, 32'd0);
    chk("t3_wdata_last", s_hwdata, dw[3]);
    repeat (3) step();

    // Slave wait states on a CPU read while debug requests
    do_reset();
    for (int i = 0; i < 16; i++) push(0, 2'b10, 3'b000, 32'h6000 + 32'(4*i), 1'b0, 32'd0);
    push(1, 2'b10, 3'b000, 32'h7000, 1'b0, 32'd0);
    step();
    repeat (3) sq.push_back(1'b0);
    for (int c = 2; c <= 19; c++) begin
      step();
      chk("t4_grant_wait", grant, 32'd0);
      if (c <= 4) chk("t4_m0_wait", m0_hready, 32'd0);
    end
    step();
    chk("t4_grant_sw", grant, 32'd1);
    repeat (3) step();

    // Debug override raised mid CPU INCR8
    do_reset();
    push(0, 2'b10, 3'b101, 32'h8000, 1'b0, 32'd0);
    for (int i = 1; i < 8; i++) push(0, 2'b11, 3'b101, 32'h8000 + 32'(4*i), 1'b0, 32'd0);
    push(0, 2'b10, 3'b000, 32'h9000, 1'b0, 32'd0);
    push(0, 2'b10, 3'b000, 32'h9004, 1'b0, 32'd0);
    push(1, 2'b10, 3'b000, 32'hA000, 1'b1, 32'hA5A5A5A5);
    step();
    step();
    ovr_req = 1;
    for (int c = 3; c <= 8; c++) begin
      step();
      chk("t5_burst_keeps", grant, 32'd0);
    end
    step();
    chk("t5_grant_dbg", grant, 32'd1);
    for (int c = 10; c <= 12; c++) begin
      step();
      chk("t5_m0_locked", m0_hready, 32'd0);
      chk("t5_grant_locked", grant, 32'd1);
    end
    ovr_req = 0;
    step();
    step();
    chk("t5_grant_release", grant, 32'd0);
    repeat (2) step();

    // Reset in the middle of a debug burst
    do_reset();
    push(1, 2'b10, 3'b011, 32'hB000, 1'b1, 32'h11111111);
    for (int i = 1; i < 4; i++) push(1, 2'b11, 3'b011, 32'hB000 + 32'(4*i), 1'b1, 32'h11111111);
    repeat (3) step();
    chk("t6_grant_pre", grant, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_htrans_idle", s_htrans, 32'd0);
    chk("t6_grant_rst", grant, 32'd0);
    chk("t6_m0_hready", m0_hready, 32'd1);
    chk("t6_m1_hready", m1_hready, 32'd1);
    do_reset();
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
